// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bus layout and the MA-stage FSM encoding.
package pipe_pkg;

   localparam int unsigned CB_W     = 22;

   // Control-bus bit positions, shared with the EX and RW stages
   localparam int unsigned CB_IS_LD = 0;
   localparam int unsigned CB_IS_ST = 1;
   localparam int unsigned CB_IS_WB = 2;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StReq  = 1'b1
   } ma_state_t;

endpackage

// File: rtl/ma_timeout_ctr.sv
// Wait-cycle counter for an outstanding data-memory request; tc_o flags the last allowed cycle.
module ma_timeout_ctr #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic tc_o
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CntW-1:0] Last = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tc_o = (cnt_q == Last);

   // Next count: clear wins; hold at terminal count so the value never wraps
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && !tc_o) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   // Count register, falling-edge like the pipeline latches
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ma_stage.sv
// Memory-access stage: issues loads/stores over a req/ready port and fills the MA/RW register.
module ma_stage
   import pipe_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ma_valid,
   input  logic [31:0]       ma_pc,
   input  logic [31:0]       ma_alu_result,
   input  logic [31:0]       ma_op2,
   input  logic [31:0]       ma_ir,
   input  logic [CB_W-1:0]   ma_control_bus,
   output logic              stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   input  logic              dmem_ready,
   input  logic [31:0]       dmem_rdata,
   output logic              rw_valid,
   output logic [31:0]       rw_pc,
   output logic [31:0]       rw_alu_result,
   output logic [31:0]       rw_ld_result,
   output logic [31:0]       rw_ir,
   output logic [CB_W-1:0]   rw_control_bus,
   output logic              bus_err
);

   ma_state_t         state_q, state_d;
   logic              dmem_req_q, dmem_req_d;
   logic              dmem_we_q, dmem_we_d;
   logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
   logic [31:0]       dmem_wdata_q, dmem_wdata_d;
   logic              rw_valid_q, rw_valid_d;
   logic [31:0]       rw_pc_q, rw_pc_d;
   logic [31:0]       rw_alu_q, rw_alu_d;
   logic [31:0]       rw_ld_q, rw_ld_d;
   logic [31:0]       rw_ir_q, rw_ir_d;
   logic [CB_W-1:0]   rw_cb_q, rw_cb_d;
   logic              bus_err_q, bus_err_d;

   logic is_ld, is_st, mem_op, in_req, tc, timeout_hit;

   assign is_ld       = ma_control_bus[CB_IS_LD];
   assign is_st       = ma_control_bus[CB_IS_ST];
   assign mem_op      = ma_valid & (is_ld | is_st);
   assign in_req      = (state_q == StReq);
   assign timeout_hit = in_req & tc;

   // Release upstream on the completing edge so the instruction is not re-issued
   assign stall = mem_op & ~(in_req & (dmem_ready | timeout_hit));

   ma_timeout_ctr #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear_i  (~in_req),
      .enable_i (in_req & ~dmem_ready),
      .tc_o     (tc)
   );

   // Next-state: issue from IDLE, wait in REQ, complete on ready or timeout
   always_comb begin
      state_d      = state_q;
      dmem_req_d   = dmem_req_q;
      dmem_we_d    = dmem_we_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_wdata_d = dmem_wdata_q;
      rw_valid_d   = 1'b0;
      rw_pc_d      = rw_pc_q;
      rw_alu_d     = rw_alu_q;
      rw_ld_d      = rw_ld_q;
      rw_ir_d      = rw_ir_q;
      rw_cb_d      = rw_cb_q;
      bus_err_d    = bus_err_q;
      case (state_q)
         StIdle: begin
            if (mem_op) begin
               state_d      = StReq;
               dmem_req_d   = 1'b1;
               dmem_we_d    = is_st;
               dmem_addr_d  = ma_alu_result[ADDR_W-1:0];
               dmem_wdata_d = ma_op2;
            end else begin
               rw_valid_d = ma_valid;
               rw_pc_d    = ma_pc;
               rw_alu_d   = ma_alu_result;
               rw_ld_d    = '0;
               rw_ir_d    = ma_ir;
               rw_cb_d    = ma_control_bus;
            end
         end
         StReq: begin
            if (dmem_ready || timeout_hit) begin
               state_d    = StIdle;
               dmem_req_d = 1'b0;
               rw_valid_d = 1'b1;
               rw_pc_d    = ma_pc;
               rw_alu_d   = ma_alu_result;
               rw_ir_d    = ma_ir;
               rw_cb_d    = ma_control_bus;
               // Ready on the terminal-count edge still counts as a normal completion
               rw_ld_d    = (dmem_ready && is_ld) ? dmem_rdata : '0;
               if (!dmem_ready) begin
                  bus_err_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and pipeline-register update on the falling edge
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= '0;
         rw_valid_q   <= 1'b0;
         rw_pc_q      <= '0;
         rw_alu_q     <= '0;
         rw_ld_q      <= '0;
         rw_ir_q      <= '0;
         rw_cb_q      <= '0;
         bus_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         dmem_req_q   <= dmem_req_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_wdata_q <= dmem_wdata_d;
         rw_valid_q   <= rw_valid_d;
         rw_pc_q      <= rw_pc_d;
         rw_alu_q     <= rw_alu_d;
         rw_ld_q      <= rw_ld_d;
         rw_ir_q      <= rw_ir_d;
         rw_cb_q      <= rw_cb_d;
         bus_err_q    <= bus_err_d;
      end
   end

   assign dmem_req       = dmem_req_q;
   assign dmem_we        = dmem_we_q;
   assign dmem_addr      = dmem_addr_q;
   assign dmem_wdata     = dmem_wdata_q;
   assign rw_valid       = rw_valid_q;
   assign rw_pc          = rw_pc_q;
   assign rw_alu_result  = rw_alu_q;
   assign rw_ld_result   = rw_ld_q;
   assign rw_ir          = rw_ir_q;
   assign rw_control_bus = rw_cb_q;
   assign bus_err        = bus_err_q;

endmodule

// File: tb/tb_ma_stage.sv
// Bench for ma_stage: directed scenarios plus random instruction streams against a
// transaction-level model (expected stall count, request count, writeback values).
module tb_ma_stage;
   import pipe_pkg::*;

   localparam int TO = 64;

   logic            clk;
   logic            rst_n;
   logic            ma_valid;
   logic [31:0]     ma_pc, ma_alu_result, ma_op2, ma_ir;
   logic [CB_W-1:0] ma_control_bus;
   logic            stall, dmem_req, dmem_we, dmem_ready;
   logic [31:0]     dmem_addr, dmem_wdata, dmem_rdata;
   logic            rw_valid;
   logic [31:0]     rw_pc, rw_alu_result, rw_ld_result, rw_ir;
   logic [CB_W-1:0] rw_control_bus;
   logic            bus_err;

   ma_stage #(
      .ADDR_W         (32),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ma_valid       (ma_valid),
      .ma_pc          (ma_pc),
      .ma_alu_result  (ma_alu_result),
      .ma_op2         (ma_op2),
      .ma_ir          (ma_ir),
      .ma_control_bus (ma_control_bus),
      .stall          (stall),
      .dmem_req       (dmem_req),
      .dmem_we        (dmem_we),
      .dmem_addr      (dmem_addr),
      .dmem_wdata     (dmem_wdata),
      .dmem_ready     (dmem_ready),
      .dmem_rdata     (dmem_rdata),
      .rw_valid       (rw_valid),
      .rw_pc          (rw_pc),
      .rw_alu_result  (rw_alu_result),
      .rw_ld_result   (rw_ld_result),
      .rw_ir          (rw_ir),
      .rw_control_bus (rw_control_bus),
      .bus_err        (bus_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;

   // Request-pulse monitor: counts rising edges of dmem_req and the low gap before each
   int   req_rises = 0;
   int   low_run   = 0;
   int   last_gap  = 0;
   logic prev_req  = 1'b0;
   always @(posedge clk) begin
      if (dmem_req && !prev_req) begin
         req_rises <= req_rises + 1;
         last_gap  <= low_run;
      end
      low_run  <= dmem_req ? 0 : low_run + 1;
      prev_req <= dmem_req;
   end

   typedef struct {
      logic            valid;
      logic            ld;
      logic            st;
      logic [31:0]     pc, alu, op2, ir;
      logic [CB_W-1:0] cb;
   } instr_t;

   typedef struct {
      int              stall_cycles;
      int              req_cycles;
      int              req_rises;
      bit              stable;
      bit              bubbles;
      bit              done;
      logic            rw_valid;
      logic [31:0]     rw_pc, rw_alu, rw_ld, rw_ir;
      logic [CB_W-1:0] rw_cb;
      logic            bus_err;
      logic            req_after;
   } obs_t;

   typedef struct {
      int          stall;
      int          reqs;
      logic [31:0] ld;
      logic        err;
      logic        valid;
   } exp_t;

   // Transaction-level model: a memory op waits n_req cycles (or TO if memory never answers)
   function automatic exp_t model(input instr_t in, input int n_req, input logic [31:0] rdata,
                                  input logic err_before);
      exp_t e;
      bit   mem  = in.valid && (in.ld || in.st);
      bit   hung = mem && (n_req <= 0 || n_req > TO);
      e.stall = !mem ? 0 : (hung ? TO : n_req);
      e.reqs  = mem ? 1 : 0;
      e.ld    = (mem && in.ld && !hung) ? rdata : 32'h0;
      e.err   = err_before | hung;
      e.valid = in.valid;
      return e;
   endfunction

   function automatic instr_t make_instr(input int kind, input logic valid);
      instr_t i;
      i.valid = valid;
      i.ld    = (kind == 1);
      i.st    = (kind == 2);
      i.pc    = $urandom;
      i.alu   = $urandom;
      i.op2   = $urandom;
      i.ir    = $urandom;
      i.cb    = CB_W'($urandom);
      i.cb[CB_IS_LD] = i.ld;
      i.cb[CB_IS_ST] = i.st;
      return i;
   endfunction

   // Present one instruction (entered at posedge+1), act as memory answering on the
   // n_req-th request cycle (never if n_req==0), and return observations after writeback.
   task automatic drive_instr(input instr_t in, input int n_req, input logic [31:0] rdata,
                              output obs_t o);
      int reqc = 0;
      int r0   = req_rises;
      o.stall_cycles = 0;
      o.stable  = 1'b1;
      o.bubbles = 1'b1;
      o.done    = 1'b0;
      ma_valid       = in.valid;
      ma_pc          = in.pc;
      ma_alu_result  = in.alu;
      ma_op2         = in.op2;
      ma_ir          = in.ir;
      ma_control_bus = in.cb;
      for (int c = 0; c < TO + 20 && !o.done; c++) begin
         if (dmem_req) begin
            reqc++;
            if (dmem_addr !== in.alu || dmem_we !== in.st || dmem_wdata !== in.op2)
               o.stable = 1'b0;
            if (rw_valid !== 1'b0) o.bubbles = 1'b0;
            dmem_ready = (reqc == n_req);
            dmem_rdata = (reqc == n_req) ? rdata : $urandom;
         end else begin
            // Ready while idle must be ignored
            dmem_ready = 1'($urandom_range(0, 1));
            dmem_rdata = $urandom;
         end
         #1;
         if (stall) o.stall_cycles++;
         else o.done = 1'b1;
         @(posedge clk);
         #1;
      end
      dmem_ready  = 1'b0;
      o.req_cycles = reqc;
      o.req_rises  = req_rises - r0;
      o.rw_valid   = rw_valid;
      o.rw_pc      = rw_pc;
      o.rw_alu     = rw_alu_result;
      o.rw_ld      = rw_ld_result;
      o.rw_ir      = rw_ir;
      o.rw_cb      = rw_control_bus;
      o.bus_err    = bus_err;
      o.req_after  = dmem_req;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ma_valid = 1'b0; ma_pc = '0; ma_alu_result = '0; ma_op2 = '0; ma_ir = '0;
      ma_control_bus = '0; dmem_ready = 1'b0; dmem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({dmem_req, dmem_we, rw_valid, bus_err, stall} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 00000", {dmem_req, dmem_we, rw_valid, bus_err, stall});
      end
      n_checks++;
      if ({dmem_addr, dmem_wdata} !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_dmem: got %h want 0", {dmem_addr, dmem_wdata});
      end
      n_checks++;
      if ({rw_pc, rw_alu_result, rw_ld_result, rw_ir, rw_control_bus} !== '0) begin
         n_fail++;
         $display("FAIL reset_rw: got %h/%h/%h/%h/%h want 0", rw_pc, rw_alu_result,
                  rw_ld_result, rw_ir, rw_control_bus);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_alu();
      instr_t in = make_instr(0, 1'b1);
      obs_t   o;
      in.alu = 32'h0000_0042;
      drive_instr(in, 0, 32'h0, o);
      n_checks++;
      if (o.stall_cycles !== 0 || !o.done) begin
         n_fail++; $display("FAIL alu_stall: got %0d want 0", o.stall_cycles);
      end
      n_checks++;
      if (o.rw_valid !== 1'b1 || o.rw_alu !== 32'h42 || o.rw_pc !== in.pc || o.rw_ir !== in.ir
          || o.rw_cb !== in.cb || o.rw_ld !== 32'h0) begin
         n_fail++;
         $display("FAIL alu_rw: got v=%b alu=%h ld=%h want v=1 alu=42 ld=0", o.rw_valid, o.rw_alu,
                  o.rw_ld);
      end
      n_checks++;
      if (o.req_rises !== 0) begin
         n_fail++; $display("FAIL alu_noreq: got %0d requests want 0", o.req_rises);
      end
   endtask

   task automatic test_load();
      instr_t in = make_instr(1, 1'b1);
      obs_t   o;
      in.alu = 32'h0000_0100;
      drive_instr(in, 3, 32'hDEAD_BEEF, o);
      n_checks++;
      if (o.stall_cycles !== 3 || !o.done) begin
         n_fail++; $display("FAIL load_stall: got %0d want 3", o.stall_cycles);
      end
      n_checks++;
      if (!o.stable || !o.bubbles || o.req_rises !== 1 || o.req_after !== 1'b0) begin
         n_fail++;
         $display("FAIL load_req: stable=%b bubbles=%b rises=%0d req_after=%b want 1 1 1 0",
                  o.stable, o.bubbles, o.req_rises, o.req_after);
      end
      n_checks++;
      if (o.rw_valid !== 1'b1 || o.rw_ld !== 32'hDEAD_BEEF || o.rw_pc !== in.pc) begin
         n_fail++;
         $display("FAIL load_rw: got v=%b ld=%h want v=1 ld=deadbeef", o.rw_valid, o.rw_ld);
      end
   endtask

   task automatic test_store();
      instr_t in = make_instr(2, 1'b1);
      obs_t   o;
      in.alu = 32'h0000_0200;
      in.op2 = 32'h1234_5678;
      drive_instr(in, 1, 32'hFFFF_FFFF, o);
      n_checks++;
      if (o.stall_cycles !== 1 || o.req_cycles !== 1 || o.req_rises !== 1 || !o.stable) begin
         n_fail++;
         $display("FAIL store_req: stall=%0d reqcyc=%0d rises=%0d stable=%b want 1 1 1 1",
                  o.stall_cycles, o.req_cycles, o.req_rises, o.stable);
      end
      n_checks++;
      if (o.rw_valid !== 1'b1 || o.rw_ld !== 32'h0 || o.rw_alu !== 32'h200) begin
         n_fail++;
         $display("FAIL store_rw: got v=%b ld=%h alu=%h want 1 0 200", o.rw_valid, o.rw_ld,
                  o.rw_alu);
      end
   endtask

   task automatic test_back_to_back();
      instr_t a = make_instr(1, 1'b1);
      instr_t b = make_instr(1, 1'b1);
      obs_t   oa, ob;
      logic [31:0] da = $urandom;
      logic [31:0] db = $urandom;
      drive_instr(a, 2, da, oa);
      drive_instr(b, 2, db, ob);
      n_checks++;
      if (oa.rw_ld !== da || oa.rw_pc !== a.pc || ob.rw_ld !== db || ob.rw_pc !== b.pc) begin
         n_fail++;
         $display("FAIL b2b_order: got %h@%h %h@%h want %h@%h %h@%h", oa.rw_ld, oa.rw_pc,
                  ob.rw_ld, ob.rw_pc, da, a.pc, db, b.pc);
      end
      n_checks++;
      if (oa.req_rises !== 1 || ob.req_rises !== 1 || last_gap !== 1) begin
         n_fail++;
         $display("FAIL b2b_req: rises=%0d,%0d gap=%0d want 1,1 gap 1", oa.req_rises,
                  ob.req_rises, last_gap);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 40; k++) begin
         int          kind  = $urandom_range(0, 2);
         logic        valid = ($urandom_range(0, 5) != 0);
         int          n_req = $urandom_range(1, 6);
         logic [31:0] rdata = $urandom;
         instr_t      in    = make_instr(kind, valid);
         exp_t        e     = model(in, n_req, rdata, bus_err);
         obs_t        o;
         drive_instr(in, n_req, rdata, o);
         n_checks++;
         if (o.stall_cycles !== e.stall || o.req_rises !== e.reqs || !o.done) begin
            n_fail++;
            $display("FAIL rnd_timing[%0d]: stall=%0d reqs=%0d want %0d %0d", k,
                     o.stall_cycles, o.req_rises, e.stall, e.reqs);
         end
         n_checks++;
         if (o.rw_valid !== e.valid || o.bus_err !== e.err || !o.stable || !o.bubbles) begin
            n_fail++;
            $display("FAIL rnd_flags[%0d]: v=%b err=%b stable=%b bub=%b want v=%b err=%b", k,
                     o.rw_valid, o.bus_err, o.stable, o.bubbles, e.valid, e.err);
         end
         if (valid) begin
            n_checks++;
            if (o.rw_ld !== e.ld || o.rw_pc !== in.pc || o.rw_alu !== in.alu
                || o.rw_ir !== in.ir || o.rw_cb !== in.cb) begin
               n_fail++;
               $display("FAIL rnd_rw[%0d]: ld=%h pc=%h want ld=%h pc=%h", k, o.rw_ld, o.rw_pc,
                        e.ld, in.pc);
            end
         end
      end
   endtask

   task automatic test_ready_at_tc();
      instr_t      in    = make_instr(1, 1'b1);
      logic [31:0] rdata = $urandom;
      exp_t        e     = model(in, TO, rdata, 1'b0);
      obs_t        o;
      drive_instr(in, TO, rdata, o);
      n_checks++;
      if (o.bus_err !== e.err || o.rw_ld !== e.ld || o.stall_cycles !== e.stall) begin
         n_fail++;
         $display("FAIL ready_at_tc: err=%b ld=%h stall=%0d want %b %h %0d", o.bus_err,
                  o.rw_ld, o.stall_cycles, e.err, e.ld, e.stall);
      end
   endtask

   task automatic test_timeout();
      instr_t in  = make_instr(1, 1'b1);
      instr_t alu = make_instr(0, 1'b1);
      exp_t   e   = model(in, 0, 32'h0, 1'b0);
      obs_t   o;
      drive_instr(in, 0, 32'h0, o);
      n_checks++;
      if (o.bus_err !== 1'b1 || o.req_after !== 1'b0 || o.req_cycles !== TO) begin
         n_fail++;
         $display("FAIL timeout_err: err=%b req=%b reqcyc=%0d want 1 0 %0d", o.bus_err,
                  o.req_after, o.req_cycles, TO);
      end
      n_checks++;
      if (o.rw_valid !== 1'b1 || o.rw_ld !== e.ld || o.stall_cycles !== e.stall) begin
         n_fail++;
         $display("FAIL timeout_rw: v=%b ld=%h stall=%0d want 1 %h %0d", o.rw_valid, o.rw_ld,
                  o.stall_cycles, e.ld, e.stall);
      end
      drive_instr(alu, 0, 32'h0, o);
      n_checks++;
      if (o.rw_valid !== 1'b1 || o.rw_alu !== alu.alu || o.stall_cycles !== 0
          || o.bus_err !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_resume: v=%b alu=%h stall=%0d err=%b want 1 %h 0 1",
                  o.rw_valid, o.rw_alu, o.stall_cycles, o.bus_err, alu.alu);
      end
   endtask

   task automatic test_reset_mid_req();
      instr_t in = make_instr(1, 1'b1);
      instr_t st = make_instr(2, 1'b1);
      obs_t   o;
      ma_valid = in.valid; ma_pc = in.pc; ma_alu_result = in.alu; ma_op2 = in.op2;
      ma_ir = in.ir; ma_control_bus = in.cb; dmem_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      n_checks++;
      if (dmem_req !== 1'b1) begin
         n_fail++; $display("FAIL midreq_pending: req=%b want 1", dmem_req);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({dmem_req, dmem_we, rw_valid, bus_err} !== 4'b0 || dmem_addr !== 32'h0
          || dmem_wdata !== 32'h0 || rw_pc !== 32'h0 || rw_ld_result !== 32'h0) begin
         n_fail++;
         $display("FAIL midreq_reset: req=%b we=%b v=%b err=%b addr=%h want all 0", dmem_req,
                  dmem_we, rw_valid, bus_err, dmem_addr);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive_instr(st, 2, 32'h0, o);
      n_checks++;
      if (o.req_rises !== 1 || o.stall_cycles !== 2 || o.rw_valid !== 1'b1
          || o.rw_pc !== st.pc || o.bus_err !== 1'b0 || !o.stable) begin
         n_fail++;
         $display("FAIL midreq_fresh: rises=%0d stall=%0d v=%b pc=%h err=%b want 1 2 1 %h 0",
                  o.req_rises, o.stall_cycles, o.rw_valid, o.rw_pc, o.bus_err, st.pc);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_back_to_back();
      test_random();
      test_ready_at_tc();
      test_timeout();
      test_reset_mid_req();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ma_stage.md
# ma_stage

Memory-access stage of the five-stage pipeline: it consumes the EX/MA pipeline register outputs, performs loads and stores against the data memory, and fills the MA/RW pipeline register. Data memory is reached through a req/ready handshake with variable latency. The stage asserts `stall` back to the upstream latches while an access is outstanding. A timeout counter converts a hung memory into a sticky bus error instead of a permanent pipeline freeze.

## Interface
Parameters:
- `ADDR_W`, 32: data-memory address width; `dmem_addr` = `ma_alu_result[ADDR_W-1:0]`.
- `TIMEOUT_CYCLES`, 64: maximum cycles `dmem_req` is held without `dmem_ready`; must be ≥ 2.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the falling edge, consistent with the pipeline latches.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ma_valid`  in  1  EX/MA register holds a real instruction (0 = bubble).
- `ma_pc`  in  32  instruction PC.
- `ma_alu_result`  in  32  effective address for ld/st; ALU result otherwise.
- `ma_op2`  in  32  store data.
- `ma_ir`  in  32  instruction word.
- `ma_control_bus`  in  22  decoded control bus.
- `stall`  out  1  combinational; upstream latches hold while 1.
- `dmem_req`  out  1  memory request.
- `dmem_we`  out  1  1 = store, 0 = load.
- `dmem_addr`  out  ADDR_W  byte address.
- `dmem_wdata`  out  32  store data.
- `dmem_ready`  in  1  access complete; `dmem_rdata` valid for loads.
- `dmem_rdata`  in  32  load data.
- `rw_valid`  out  1  MA/RW register holds a real instruction.
- `rw_pc`, `rw_alu_result`, `rw_ld_result`, `rw_ir`  out  32 each  MA/RW register fields.
- `rw_control_bus`  out  22  forwarded control bus.
- `bus_err`  out  1  sticky timeout flag.

## Operation
- `mem_op` = `ma_valid & (is_ld | is_st)`. Bit positions come from `pipe_pkg`.
- FSM states: IDLE and REQ.
- IDLE with `mem_op`:
  - Go to REQ.
  - Register `dmem_req`=1, `dmem_we`=is_st, `dmem_addr`, and `dmem_wdata`=`ma_op2`.
  - Clear the timeout counter.
  - Write a bubble to RW (`rw_valid`=0).
- IDLE without `mem_op`:
  - Copy pc/alu_result/ir/control_bus to RW.
  - `rw_ld_result`=0 and `rw_valid`=`ma_valid`.
  - No stall.
- REQ with `dmem_ready`=1 at the edge:
  - Drop `dmem_req` and return to IDLE.
  - Write the instruction to RW with `rw_valid`=1.
  - `rw_ld_result`=`dmem_rdata` for loads, 0 for stores.
- REQ with `dmem_ready`=0:
  - Increment the counter.
  - `dmem_*` outputs hold stable.
  - RW receives a bubble.
- Timeout: the counter reaches `TIMEOUT_CYCLES`-1 with no ready.
  - Set `bus_err` (sticky until reset) and drop `dmem_req`.
  - Complete the instruction as if ready, with `rw_ld_result`=0.
  - Return to IDLE.
- `stall` = `mem_op & ~(state==REQ & (dmem_ready | timeout_hit))`. The upstream register therefore advances on the same edge that completes the access, so no instruction is re-issued.
- Simultaneous ready and timeout on the same edge: ready wins, `bus_err` is not set.
- `dmem_ready` while IDLE is ignored.
- Reset, including mid-REQ: state IDLE and every output 0 (`dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, all `rw_*`, `bus_err`), counter 0. Any access already in progress is abandoned.

## Timing
- Non-memory instruction: 1 cycle latency, EX/MA to RW in the next falling edge.
- Memory instruction: `dmem_req` rises 1 edge after the instruction is present. Completion occurs on the first edge sampling `dmem_ready`=1. Total latency = 1 + memory wait cycles (minimum 2 edges when ready is already high in REQ).
- Stall cycles = latency − 1.
- `dmem_addr`/`dmem_we`/`dmem_wdata` are stable for the whole time `dmem_req` is high. `dmem_req` never drops before ready or timeout.
- Back-to-back memory ops: `dmem_req` goes low for exactly one cycle (IDLE) between accesses.

## Structure
- `pipe_pkg` holds:
  - `CB_W`=22.
  - Control-bus bit indices `CB_IS_LD`, `CB_IS_ST`, `CB_IS_WB`.
  - The FSM state enum `ma_state_t`.
  - It is shared with the EX and RW stages.
- One sub-module: `ma_timeout_ctr` (clear, enable, terminal-count output, parameter `TIMEOUT_CYCLES`).

## Test plan
- ALU instruction, `ma_alu_result`=0x0000_0042, `ma_valid`=1 -> next edge `rw_alu_result`=0x42, `rw_valid`=1, `stall` never 1.
- Load at 0x100, memory ready after 3 cycles with rdata 0xDEAD_BEEF -> `stall` high 3 cycles, `dmem_we`=0, `dmem_addr`=0x100 held stable, then `rw_ld_result`=0xDEAD_BEEF, `rw_valid`=1.
- Store of 0x1234_5678 to 0x200, ready immediately in REQ -> one `dmem_req` pulse with `dmem_we`=1, `dmem_wdata`=0x1234_5678, `rw_ld_result`=0, 1 stall cycle.
- Two consecutive loads -> two distinct requests with exactly one low cycle between them, both RW writebacks in order, no duplicate request.
- Ready held 0 -> after 64 REQ cycles `bus_err`=1, `dmem_req`=0, `rw_ld_result`=0, pipeline resumes. Ready and terminal count on the same edge -> `bus_err` stays 0.
- `rst_n` pulled low mid-REQ -> `dmem_req`, `rw_valid` and `stall`-driving state clear immediately, and an instruction presented after reset is released starts a fresh request.
